// File: rtl/rvm_instr_fetch.sv
// Instruction fetch/decode stage: captures a memory word on request, holds it,
// and decodes it into register addresses, immediate and instruction identifier.
module rvm_instr_fetch #(
    parameter int unsigned INSTR_W     = 6,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               f_req,
    output logic               f_ack,
    output logic               f_busy,
    input  logic [31:0]        mem_rdata,
    input  logic               mem_error,
    input  logic               mem_stall,
    output logic               i_valid,
    output logic               i_illegal,
    output logic               i_fetch_err,
    output logic [4:0]         i_rs1_addr,
    output logic [4:0]         i_rs2_addr,
    output logic [4:0]         i_rd_addr,
    output logic [31:0]        i_immediate,
    output logic [INSTR_W-1:0] i_instr,
    output logic [31:0]        i_raw
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

    state_t      state, state_nx;
    logic [31:0] ir;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        f_ack    = 1'b0;
        f_busy   = 1'b0;
        case (state)
            ST_IDLE: if (f_req) state_nx = ST_WAIT;
            ST_WAIT: begin
                f_busy = 1'b1;
                if (mem_error || !mem_stall) state_nx = ST_ACK;
            end
            ST_ACK: begin
                f_ack    = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Error takes priority over stall and leaves the held word untouched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ir          <= RESET_INSTR;
            i_valid     <= 1'b0;
            i_fetch_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (f_req) i_valid <= 1'b0;
                ST_WAIT: begin
                    if (mem_error) begin
                        i_fetch_err <= 1'b1;
                        i_valid     <= 1'b0;
                    end else if (!mem_stall) begin
                        ir          <= mem_rdata;
                        i_valid     <= 1'b1;
                        i_fetch_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel;
    logic [5:0]  code;

    assign opc   = ir[6:0];
    assign f3    = ir[14:12];
    assign f7    = ir[31:25];
    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u = {ir[31:12], 12'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    always_comb begin
        code    = 6'd0;
        imm_sel = '0;
        case (opc)
            7'h37: begin code = 6'd1; imm_sel = imm_u; end
            7'h17: begin code = 6'd2; imm_sel = imm_u; end
            7'h6F: begin code = 6'd3; imm_sel = imm_j; end
            7'h67: begin if (f3 == 3'd0) code = 6'd4; imm_sel = imm_i; end
            7'h63: begin
                imm_sel = imm_b;
                case (f3)
                    3'd0: code = 6'd5;
                    3'd1: code = 6'd6;
                    3'd4: code = 6'd7;
                    3'd5: code = 6'd8;
                    3'd6: code = 6'd9;
                    3'd7: code = 6'd10;
                    default: code = 6'd0;
                endcase
            end
            7'h03: begin
                imm_sel = imm_i;
                case (f3)
                    3'd0: code = 6'd11;
                    3'd1: code = 6'd12;
                    3'd2: code = 6'd13;
                    3'd4: code = 6'd14;
                    3'd5: code = 6'd15;
                    default: code = 6'd0;
                endcase
            end
            7'h23: begin
                imm_sel = imm_s;
                if (f3 <= 3'd2) code = 6'd16 + {3'd0, f3};
            end
            7'h13: begin
                imm_sel = imm_i;
                case (f3)
                    3'd0: code = 6'd19;
                    3'd2: code = 6'd20;
                    3'd3: code = 6'd21;
                    3'd4: code = 6'd22;
                    3'd6: code = 6'd23;
                    3'd7: code = 6'd24;
                    3'd1: if (f7 == 7'b0000000) code = 6'd25;
                    3'd5: begin
                        if (f7 == 7'b0000000)      code = 6'd26;
                        else if (f7 == 7'b0100000) code = 6'd27;
                    end
                    default: code = 6'd0;
                endcase
            end
            7'h33: begin
                case ({f7, f3})
                    10'b0000000_000: code = 6'd28;
                    10'b0100000_000: code = 6'd29;
                    10'b0000000_001: code = 6'd30;
                    10'b0000000_010: code = 6'd31;
                    10'b0000000_011: code = 6'd32;
                    10'b0000000_100: code = 6'd33;
                    10'b0000000_101: code = 6'd34;
                    10'b0100000_101: code = 6'd35;
                    10'b0000000_110: code = 6'd36;
                    10'b0000000_111: code = 6'd37;
                    default:         code = 6'd0;
                endcase
            end
            7'h0F: if (f3 == 3'd0) code = 6'd38;
            7'h73: begin
                if (ir[31:7] == 25'h0)           code = 6'd39;
                else if (ir[31:7] == 25'h0002000) code = 6'd40;
            end
            default: code = 6'd0;
        endcase
    end

    assign i_illegal   = (code == 6'd0);
    assign i_immediate = i_illegal ? '0 : imm_sel;
    assign i_instr     = INSTR_W'(code);
    assign i_rs1_addr  = ir[19:15];
    assign i_rs2_addr  = ir[24:20];
    assign i_rd_addr   = ir[11:7];
    assign i_raw       = ir;

endmodule
